mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Two-requester arbiter and sequencer for the single data-memory port. Port 0 is the data cache's backing-store interface. Port 1 is a secondary master, either the instruction-fetch refill or the DMA engine. The block picks one request at a time, drives the memory port for exactly one transaction, waits out the fixed read latency, and returns data with a one-cycle acknowledge. It sits between the data cache and data memory.

## Interface
Parameters:
- ADDR_W, 8, address width
- DATA_W, 8, data width
- MEM_LATENCY, 2, cycles from the mem_re cycle to valid mem_rdata; legal range 1..7

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset; asynchronous assert, active-low
- p0_req / p1_req  in  1  request; held high until ack
- p0_we / p1_we  in  1  1 = write, 0 = read; stable while req high
- p0_addr / p1_addr  in  ADDR_W  transaction address
- p0_wdata / p1_wdata  in  DATA_W  write data
- p0_ack / p1_ack  out  1  one-cycle completion pulse
- p0_rdata / p1_rdata  out  DATA_W  read data; valid in the ack cycle, held until next ack on that port
- mem_addr  out  ADDR_W  memory address
- mem_re  out  1  memory read strobe
- mem_we  out  1  memory write strobe
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high in any state other than IDLE
- grant_id  out  1  port currently being served; valid while busy

## Operation
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - If any req is high, choose the winner.
  - Latch the winner's we, addr and wdata into internal registers.
  - Set grant_id to the winner and go to ISSUE.
- ISSUE:
  - Drive mem_addr and mem_wdata from the latches.
  - Pulse mem_re or mem_we for exactly this one cycle.
  - Write: go to ACK. Read: load the latency counter with MEM_LATENCY and go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1, capture mem_rdata into the granted port's rdata register and go to ACK.
- ACK:
  - Assert ack on the granted port only, for one cycle, then go to IDLE.
- Arbitration, single requester: a lone request always wins.
- Arbitration, both requesting in IDLE: decided by the configuration below.
- Requester rule: req must be low in the cycle after ack. If it is still high, IDLE treats it as a new request.
- A req arriving while busy is not sampled until IDLE. Requests are never dropped.
- mem_addr and mem_wdata hold their last values outside ISSUE. mem_re and mem_we are 0 outside ISSUE.

## Timing
- Let cycle 0 be the first IDLE cycle in which req is high.
- Write: mem_we is high in cycle 1, ack in cycle 2.
- Read: mem_re is high in cycle 1, mem_rdata is sampled at the end of cycle 1+MEM_LATENCY, ack in cycle 2+MEM_LATENCY.
- Back-to-back throughput:
  - Write: one per 3 cycles (ISSUE, ACK, IDLE).
  - Read: one per MEM_LATENCY+3 cycles.
- Reset values: every output is 0, state is IDLE, last_grant is 1 (so port 0 wins the first tie), counter is 0.
- Reset mid-transaction: the FSM returns to IDLE immediately, no ack is issued, and the transaction is lost; the requester reissues. A memory write already strobed stays committed.
- p0_rdata and p1_rdata update only in the capture cycle of a read to that port. Writes do not change them.

## Configuration
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: on a tie, the port not served last wins. last_grant updates on every grant.
- Undefined: fixed priority, port 0 always wins ties, and the last_grant register is not built. Port 1 can starve under continuous port-0 traffic; this is accepted.

## Structure
- Shared package mem_arb_pkg holds:
  - FSM state encoding localparams (2 bits)
  - port ID constants PORT_DCACHE = 0 and PORT_AUX = 1
  - maximum latency constant, 7
- One sub-module, mem_arb_pick: a 2-input picker holding the last_grant flop, compiled per the macro.
- The FSM, latches and counter stay in the top module.

## Test plan
- Single read: MEM_LATENCY=2, p0 read at 0x3A, memory returns 0x5C. Expect mem_re in cycle 1 only, p0_ack in cycle 4, p0_rdata=0x5C, p1_ack never asserted.
- Single write: p1 write of 0x77 to 0x10. Expect mem_we, mem_addr=0x10 and mem_wdata=0x77 in cycle 1, p1_ack in cycle 2, p1_rdata unchanged.
- Tie, round-robin build: p0 and p1 both request reads in the same cycle, repeated 4 times. Expect grant order 0,1,0,1.
- Tie, fixed-priority build: same stimulus as above. Expect grant order 0,0,0,0 while p0 keeps requesting; p1 is served once p0 drops req.
- Reset mid-read: assert rst_n low during WAIT. Expect all outputs 0 immediately, no ack, and a clean reissued read completing normally after release.
- Latency sweep: MEM_LATENCY=1 and MEM_LATENCY=7. Expect read ack in cycle 3 and cycle 9 respectively, with correct data.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared constants for the data-memory port arbiter: FSM state
//            encoding, requester port IDs and the latency-counter sizing.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  // Sequencer states (2-bit encoding)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_ACK   = 2'd3;

  // Requester port identifiers
  localparam logic PORT_DCACHE = 1'b0;
  localparam logic PORT_AUX    = 1'b1;

  // Largest supported read latency; the counter is sized to hold it
  localparam int MAX_LATENCY = 7;
  localparam int CNT_W       = $clog2(MAX_LATENCY + 1);

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pick
// Purpose  : Two-input request picker. A lone request always wins. On a tie
//            the build option MEM_ARB_ROUND_ROBIN_EN selects round-robin
//            (port not served last wins, last_grant flop present); without
//            it port 0 wins every tie and no state is kept.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_pick
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic clk,
  input  logic rst_n,
  input  logic grant_en_i,
`endif
  input  logic req0_i,
  input  logic req1_i,
  output logic winner_o
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_grant_q;

  // Remember who was served last; reset to port 1 so port 0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= PORT_AUX;
    end else if (grant_en_i) begin
      last_grant_q <= winner_o;
    end
  end

  // Tie goes to the port that was not served last
  always_comb begin
    winner_o = PORT_DCACHE;
    if (req0_i && req1_i) begin
      winner_o = ~last_grant_q;
    end else if (req1_i) begin
      winner_o = PORT_AUX;
    end
  end
`else
  // Fixed priority: port 1 wins only when it is the sole requester
  always_comb begin
    winner_o = PORT_DCACHE;
    if (req1_i && !req0_i) begin
      winner_o = PORT_AUX;
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Arbitrates the data-cache port (0) and a secondary master (1)
//            onto one data-memory port. One transaction at a time:
//            IDLE -> ISSUE -> (WAIT for reads) -> ACK -> IDLE.
//            Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin tie
//            breaking; default is fixed priority to port 0.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req_i,
  input  logic              p0_we_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_wdata_i,
  output logic              p0_ack_o,
  output logic [DATA_W-1:0] p0_rdata_o,
  input  logic              p1_req_i,
  input  logic              p1_we_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_wdata_i,
  output logic              p1_ack_o,
  output logic [DATA_W-1:0] p1_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_re_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o,
  output logic              grant_id_o
);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]        state_q, state_d;
  logic              grant_q, grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;

  logic w_any_req;
  logic w_winner;

  assign w_any_req = p0_req_i | p1_req_i;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic w_grant_en;
  assign w_grant_en = (state_q == ST_IDLE) && w_any_req;
`endif

  mem_arb_pick u_pick (
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .clk        (clk),
    .rst_n      (rst_n),
    .grant_en_i (w_grant_en),
`endif
    .req0_i     (p0_req_i),
    .req1_i     (p1_req_i),
    .winner_o   (w_winner)
  );

  // Next-state logic: grant and latch in IDLE, strobe in ISSUE, count in WAIT
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    p0_rdata_d = p0_rdata_q;
    p1_rdata_d = p1_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (w_any_req) begin
          grant_d = w_winner;
          we_d    = (w_winner == PORT_AUX) ? p1_we_i    : p0_we_i;
          addr_d  = (w_winner == PORT_AUX) ? p1_addr_i  : p0_addr_i;
          wdata_d = (w_winner == PORT_AUX) ? p1_wdata_i : p0_wdata_i;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (we_q) begin
          state_d = ST_ACK;
        end else begin
          cnt_d   = LAT_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Counter runs MEM_LATENCY..1; data is valid in the cycle it reads 1
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          if (grant_q == PORT_AUX) begin
            p1_rdata_d = mem_rdata_i;
          end else begin
            p0_rdata_d = mem_rdata_i;
          end
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= PORT_DCACHE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
    end
  end

  // Outputs decode directly from registers so reset clears them at once
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_re_o    = (state_q == ST_ISSUE) && !we_q;
  assign mem_we_o    = (state_q == ST_ISSUE) && we_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign grant_id_o  = grant_q;
  assign p0_ack_o    = (state_q == ST_ACK) && (grant_q == PORT_DCACHE);
  assign p1_ack_o    = (state_q == ST_ACK) && (grant_q == PORT_AUX);
  assign p0_rdata_o  = p0_rdata_q;
  assign p1_rdata_o  = p1_rdata_q;

endmodule
`default_nettype wire
